// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// input from branch resolution, and the decode-slot handshake.
interface fetch_stage_if;
  logic        PCSrc_W;
  logic [31:0] PCBranch_W;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_D;
  logic        ready_D;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc_plus4_D;

  // Fetch-stage side.
  modport master (
    input  PCSrc_W, PCBranch_W, imem_rvalid, imem_rdata, ready_D,
    output imem_req, imem_addr, valid_D, instr_D, pc_D, pc_plus4_D
  );

  // Environment side: memory, branch unit and decode.
  modport slave (
    output PCSrc_W, PCBranch_W, imem_rvalid, imem_rdata, ready_D,
    input  imem_req, imem_addr, valid_D, instr_D, pc_D, pc_plus4_D
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the fetch PC, issues at most one memory
// request at a time, fills a single decode slot, and handles redirects by
// discarding any response that belongs to the abandoned path.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // free to issue a request
    WAIT  = 2'd1,  // one request outstanding, response wanted
    DRAIN = 2'd2   // one request outstanding, response to be discarded
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic        r_valid_d;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;

  logic        w_slot_free;
  logic        w_transfer;
  logic        w_issue;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  // The slot can take a new instruction if it is empty or emptying this edge.
  assign w_slot_free   = !r_valid_d || bus.ready_D;
  assign w_transfer    = r_valid_d && bus.ready_D;
  // Redirect targets are word aligned; the low two bits are discarded.
  assign w_redirect_pc = bus.PCBranch_W & ~32'h0000_0003;
  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign w_pc_plus4    = r_pc_f + 32'd4;

  // Request strobe must react in the same cycle to a redirect, so it is
  // decoded from state rather than registered; gated by rst_n so nothing
  // is requested while reset is held.
  assign w_issue       = rst_n && (r_state == IDLE) && w_slot_free && !bus.PCSrc_W;

  assign bus.imem_req   = w_issue;
  assign bus.imem_addr  = r_pc_f;
  assign bus.valid_D    = r_valid_d;
  assign bus.instr_D    = r_instr_d;
  assign bus.pc_D       = r_pc_d;
  assign bus.pc_plus4_D = r_pc_plus4_d;

  // FSM, fetch PC and decode slot, updated together so a redirect can
  // override a transfer or a response load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc_f       <= RESET_PC;
      r_valid_d    <= 1'b0;
      // NOTE: the slot payload is reset too, so decode never sees X even
      // though valid_D alone would make it don't-care.
      r_instr_d    <= '0;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
    end else begin
      // NOTE: non-blocking assignments let later branches override this
      // default drop of valid_D without ordering hazards.
      if (w_transfer) begin
        r_valid_d <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          // Stray rvalid here belongs to nothing outstanding and is ignored.
          if (bus.PCSrc_W) begin
            r_pc_f    <= w_redirect_pc;
            r_valid_d <= 1'b0;
          end else if (w_slot_free) begin
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (bus.PCSrc_W) begin
            r_pc_f    <= w_redirect_pc;
            r_valid_d <= 1'b0;
            r_state   <= bus.imem_rvalid ? IDLE : DRAIN;
          end else if (bus.imem_rvalid) begin
            r_instr_d    <= bus.imem_rdata;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
            r_pc_f       <= w_pc_plus4;
            r_state      <= IDLE;
          end
        end

        DRAIN: begin
          if (bus.PCSrc_W) begin
            r_pc_f    <= w_redirect_pc;
            r_valid_d <= 1'b0;
          end
          // The stale response is swallowed; the slot and pc_F stay put.
          if (bus.imem_rvalid) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Each table row is one clock
// cycle: inputs are driven after the falling edge and outputs are compared
// 1 ns later, before the next rising edge.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        src;
    logic [31:0] br;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vd;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic src, input logic [31:0] br,
                     input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_vd,
                     input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.src = src; v.br = br; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vd = e_vd;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc4 = e_pc4;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic src, input logic [31:0] br,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    rst_n           = rst;
    bus.PCSrc_W     = src;
    bus.PCBranch_W  = br;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.ready_D     = rdy;
  endtask

  initial begin
    // Global watchdog so the run can never hang.
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    //   rst src br            rv rd            rdy | req addr          vD instr         pc_D          pc_plus4_D
    // Reset held, then release: requests 0x0, 0x4, 0x8 in alternate cycles.
    add(0, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         32'h0,         32'h0);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         32'h0,         32'h0);
    add(1, 0, 32'h0,         1, 32'hAAAA_0000, 1,   0, 32'h0,         0, 32'h0,         32'h0,         32'h0);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h4,         1, 32'hAAAA_0000, 32'h0,         32'h4);
    add(1, 0, 32'h0,         1, 32'hAAAA_0004, 1,   0, 32'h0,         0, 32'hAAAA_0000, 32'h0,         32'h4);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h8,         1, 32'hAAAA_0004, 32'h4,         32'h8);
    add(1, 0, 32'h0,         1, 32'hAAAA_0008, 1,   0, 32'h0,         0, 32'hAAAA_0004, 32'h4,         32'h8);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'hC,         1, 32'hAAAA_0008, 32'h8,         32'hC);
    add(1, 0, 32'h0,         1, 32'hAAAA_000C, 1,   0, 32'h0,         0, 32'hAAAA_0008, 32'h8,         32'hC);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h10,        1, 32'hAAAA_000C, 32'hC,         32'h10);
    // Slot fills at 0x10 while ready_D=0 for 5 cycles; stray rvalid in IDLE.
    add(1, 0, 32'h0,         1, 32'hAAAA_0010, 0,   0, 32'h0,         0, 32'hAAAA_000C, 32'hC,         32'h10);
    add(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         1, 32'hDEAD_BEEF, 0,   0, 32'h0,         1, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h14,        1, 32'hAAAA_0010, 32'h10,        32'h14);
    // Latency-2 response.
    add(1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         1, 32'hAAAA_0014, 1,   0, 32'h0,         0, 32'hAAAA_0010, 32'h10,        32'h14);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h18,        1, 32'hAAAA_0014, 32'h14,        32'h18);
    add(1, 0, 32'h0,         1, 32'hAAAA_0018, 1,   0, 32'h0,         0, 32'hAAAA_0014, 32'h14,        32'h18);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h1C,        1, 32'hAAAA_0018, 32'h18,        32'h1C);
    add(1, 0, 32'h0,         1, 32'hAAAA_001C, 1,   0, 32'h0,         0, 32'hAAAA_0018, 32'h18,        32'h1C);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h20,        1, 32'hAAAA_001C, 32'h1C,        32'h20);
    // Redirect to 0x103 while WAIT at 0x20; response 2 cycles later is dropped.
    add(1, 1, 32'h0000_0103, 0, 32'h0,         1,   0, 32'h0,         0, 32'hAAAA_001C, 32'h1C,        32'h20);
    add(1, 0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         0, 32'hAAAA_001C, 32'h1C,        32'h20);
    add(1, 0, 32'h0,         1, 32'hAAAA_0020, 1,   0, 32'h0,         0, 32'hAAAA_001C, 32'h1C,        32'h20);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h100,       0, 32'hAAAA_001C, 32'h1C,        32'h20);
    add(1, 0, 32'h0,         1, 32'hBBBB_0100, 1,   0, 32'h0,         0, 32'hAAAA_001C, 32'h1C,        32'h20);
    // Redirect to 0x200 with transfer and stray rvalid on the same edge.
    add(1, 1, 32'h0000_0200, 1, 32'hCCCC_0000, 1,   0, 32'h0,         1, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h200,       0, 32'hBBBB_0100, 32'h100,       32'h104);
    // Redirect in WAIT coincident with the response: response dropped.
    add(1, 1, 32'h0000_0300, 1, 32'hCCCC_0200, 1,   0, 32'h0,         0, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h300,       0, 32'hBBBB_0100, 32'h100,       32'h104);
    // Redirect into DRAIN, redirect again while draining, then wrap at top of memory.
    add(1, 1, 32'h0000_0400, 0, 32'h0,         1,   0, 32'h0,         0, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 1, 32'hFFFF_FFFF, 0, 32'h0,         1,   0, 32'h0,         0, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 0, 32'h0,         1, 32'hCCCC_0300, 1,   0, 32'h0,         0, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 0, 32'h0,         1, 32'hDDDD_FFFC, 1,   0, 32'h0,         0, 32'hBBBB_0100, 32'h100,       32'h104);
    add(1, 0, 32'h0,         0, 32'h0,         1,   1, 32'h0,         1, 32'hDDDD_FFFC, 32'hFFFF_FFFC, 32'h0);
    add(1, 0, 32'h0,         1, 32'hEEEE_0000, 0,   0, 32'h0,         0, 32'hDDDD_FFFC, 32'hFFFF_FFFC, 32'h0);
    // Full slot stalled, redirect clears it; request resumes at 0x500.
    add(1, 0, 32'h0,         0, 32'h0,         0,   0, 32'h0,         1, 32'hEEEE_0000, 32'h0,         32'h4);
    add(1, 1, 32'h0000_0500, 0, 32'h0,         0,   0, 32'h0,         1, 32'hEEEE_0000, 32'h0,         32'h4);
    add(1, 0, 32'h0,         0, 32'h0,         0,   1, 32'h500,       0, 32'hEEEE_0000, 32'h0,         32'h4);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].src, vecs[i].br, vecs[i].rv, vecs[i].rd, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      end
      check($sformatf("v%0d_valid", i), {31'b0, bus.valid_D}, {31'b0, vecs[i].e_vd});
      check($sformatf("v%0d_instr", i), bus.instr_D, vecs[i].e_instr);
      check($sformatf("v%0d_pc", i), bus.pc_D, vecs[i].e_pc);
      check($sformatf("v%0d_pc4", i), bus.pc_plus4_D, vecs[i].e_pc4);
    end

    // Reset pulsed while WAIT at 0x500: asynchronous clear, stale response
    // after release ignored, first request at the reset PC.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    check("rst_async_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_async_valid", {31'b0, bus.valid_D}, 32'd0);
    check("rst_async_instr", bus.instr_D, 32'h0);
    check("rst_async_pc", bus.pc_D, 32'h0);
    check("rst_async_pc4", bus.pc_plus4_D, 32'h0);

    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hF00D_F00D, 1'b1);
    #1;
    check("rel_req", {31'b0, bus.imem_req}, 32'd1);
    check("rel_addr", bus.imem_addr, RST_PC);
    check("rel_valid", {31'b0, bus.valid_D}, 32'd0);

    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    check("rel_wait_req", {31'b0, bus.imem_req}, 32'd0);
    check("rel_wait_valid", {31'b0, bus.valid_D}, 32'd0);

    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    #1;
    check("rel_resp_valid", {31'b0, bus.valid_D}, 32'd0);

    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    check("rel_load_valid", {31'b0, bus.valid_D}, 32'd1);
    check("rel_load_instr", bus.instr_D, 32'h1234_5678);
    check("rel_load_pc", bus.pc_D, RST_PC);
    check("rel_load_pc4", bus.pc_plus4_D, RST_PC + 32'd4);
    check("rel_next_req", {31'b0, bus.imem_req}, 32'd1);
    check("rel_next_addr", bus.imem_addr, RST_PC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  the asynchronous, active-low reset.
REQ-004 The block SHALL have port PCSrc_W  input  1  the redirect request from the branch-resolution stage.
REQ-005 The block SHALL have port PCBranch_W  input  32  the redirect target, sampled when PCSrc_W=1.
REQ-006 The block SHALL have port imem_req  output  1  the instruction-memory request strobe, one cycle per request.
REQ-007 The block SHALL have port imem_addr  output  32  the fetch address, valid while imem_req=1.
REQ-008 The block SHALL have port imem_rvalid  input  1  the response valid, arriving 1 or more cycles after its request.
REQ-009 The block SHALL have port imem_rdata  input  32  the instruction word, valid with imem_rvalid.
REQ-010 The block SHALL have port valid_D  output  1  the decode-slot-full flag.
REQ-011 The block SHALL have port ready_D  input  1  the decode-accepts-slot flag.
REQ-012 The block SHALL have ports instr_D  output  32, pc_D  output  32 and pc_plus4_D  output  32  for the decode-slot contents.

Function
REQ-013 The block SHALL hold a fetch PC register pc_F and an FSM with states IDLE (may issue), WAIT (one request outstanding) and DRAIN (outstanding response to be discarded).
REQ-014 The block SHALL never have more than one memory request outstanding.
REQ-015 imem_req SHALL be 1 exactly when state=IDLE, slot_free=1 and PCSrc_W=0, where slot_free = !valid_D | ready_D; in that case imem_addr=pc_F and the state moves to WAIT.
REQ-016 In WAIT with imem_rvalid=1 and PCSrc_W=0, the block SHALL, on the same clock edge, load instr_D=imem_rdata, pc_D=pc_F, pc_plus4_D=pc_F+4 and valid_D=1, update pc_F to pc_F+4, and return to IDLE.
REQ-017 pc_F+4 SHALL wrap modulo 2^32; for example 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-018 A decode-slot transfer SHALL occur when valid_D=1 and ready_D=1; valid_D SHALL drop the next cycle unless a new response loads the slot that same edge.
REQ-019 While valid_D=1 and ready_D=0, all decode-slot outputs SHALL hold stable.
REQ-020 A redirect (PCSrc_W=1) SHALL load pc_F with {PCBranch_W[31:2],2'b00} and clear valid_D on the same edge, overriding any simultaneous transfer or response load.
REQ-021 Redirect in IDLE: no request SHALL be issued that cycle, and the state SHALL stay IDLE.
REQ-022 Redirect in WAIT with imem_rvalid=0: the state SHALL go to DRAIN.
REQ-023 Redirect in WAIT with imem_rvalid=1: the response SHALL be dropped and the state SHALL go to IDLE.
REQ-024 Redirect in DRAIN: pc_F SHALL update and the state SHALL stay DRAIN.
REQ-025 In DRAIN, imem_rvalid=1 SHALL be dropped without touching the slot or pc_F, and the state SHALL go to IDLE.
REQ-026 imem_rvalid asserted in IDLE SHALL be ignored.
REQ-027 Redirect-to-request latency SHALL be 1 cycle from IDLE; from WAIT or DRAIN, the first request SHALL come 1 cycle after the drained response.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force state=IDLE, pc_F=RESET_PC, valid_D=0 and instr_D=pc_D=pc_plus4_D=0; imem_req SHALL be 0.
REQ-029 Reset asserted mid-WAIT SHALL abandon the outstanding request; any response arriving after release SHALL be ignored under REQ-026.
REQ-030 The first request after release SHALL be issued in the first clock cycle with rst_n=1, at imem_addr=RESET_PC.

Verification
REQ-031 Scenario: reset release with RESET_PC=0, memory latency 1, ready_D=1 -> requests at 0x0, 0x4, 0x8 in alternating cycles; pc_D sequence 0x0, 0x4, 0x8.
REQ-032 Scenario: ready_D held 0 for 5 cycles with the slot full at pc_D=0x10 -> exactly one further request (0x14) issued only after ready_D rises; instr_D stable throughout.
REQ-033 Scenario: redirect to 0x0000_0103 while WAIT at 0x20, response 2 cycles later -> 0x20 response dropped, valid_D=0, next request 0x100.
REQ-034 Scenario: PCSrc_W=1 with PCBranch_W=0x200 in the same cycle as imem_rvalid and valid_D&ready_D -> slot empty next cycle, next request 0x200.
REQ-035 Scenario: pc_F=0xFFFF_FFFC fetched -> pc_plus4_D=0x0, next request 0x0.
REQ-036 Scenario: rst_n pulsed low during WAIT, stale imem_rvalid after release -> ignored, first request at RESET_PC, valid_D=0 until its response.
